// File: rtl/wallet_key_pkg.sv
// rtl/wallet_key_pkg.sv - shared key FSM states, event record and 50 MHz timing defaults
package wallet_key_pkg;

  typedef enum logic [1:0] {
    KS_IDLE,
    KS_PRESSED,
    KS_LONG_SENT
  } key_state_e;

  typedef struct packed {
    logic [2:0] key;
    logic       is_long;
  } key_evt_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_LONG_CYCLES     = 100000000;

endpackage

// File: rtl/wallet_key_events_if.sv
// rtl/wallet_key_events_if.sv - key event queue head with valid/ack pop handshake
interface wallet_key_events_if;
  logic       evt_valid;
  logic [2:0] evt_key;
  logic       evt_long;
  logic       evt_ack;

  modport master (output evt_valid, output evt_key, output evt_long, input evt_ack);
  modport slave  (input evt_valid, input evt_key, input evt_long, output evt_ack);
endinterface

// File: rtl/wallet_key_debounce.sv
// rtl/wallet_key_debounce.sv - 2-flop synchroniser, inversion and debounce counter for one key
module wallet_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic key_level_o
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          raw_level;

  assign raw_level = ~sync_q[1];

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (raw_level == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchroniser resets to the released (high) pin level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_level_o = level_q;
endmodule

// File: rtl/wallet_key_events.sv
// rtl/wallet_key_events.sv - debounced key press classifier with event FIFO
// Long-press classification is built only when WALLET_KEY_LONGPRESS_EN is defined.
module wallet_key_events
  import wallet_key_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_level,
  wallet_key_events_if.master evt,
  output logic                evt_overflow,
  input  logic                ovf_clr
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  key_state_e    state_q [NUM_KEYS];
  key_state_e    state_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] pend_q, pend_d, plong_q, plong_d;
`ifdef WALLET_KEY_LONGPRESS_EN
  localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);
  logic [HW-1:0] hold_q [NUM_KEYS];
  logic [HW-1:0] hold_d [NUM_KEYS];
`endif

  key_evt_t      mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q;
  logic          wr_en, push, pop, full, ovf_set;
  key_evt_t      wr_evt;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_deb
    wallet_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk_i       (CLOCK_50),
      .rst_ni      (reset_n),
      .key_n_i     (KEY[g]),
      .key_level_o (key_level[g])
    );
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    plong_d = plong_q;
`ifdef WALLET_KEY_LONGPRESS_EN
    hold_d  = hold_q;
`endif
    wr_en   = 1'b0;
    wr_evt  = '0;
    // Lowest-index pending key wins; its flag clears even if the FIFO drops it.
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (pend_q[i] && !wr_en) begin
        wr_en          = 1'b1;
        wr_evt.key     = 3'(i);
        wr_evt.is_long = plong_q[i];
        pend_d[i]      = 1'b0;
      end
    end
    for (int i = 0; i < NUM_KEYS; i++) begin
      case (state_q[i])
        KS_IDLE: begin
          if (key_level[i]) begin
            state_d[i] = KS_PRESSED;
`ifdef WALLET_KEY_LONGPRESS_EN
            hold_d[i]  = '0;
`endif
          end
        end
        KS_PRESSED: begin
`ifdef WALLET_KEY_LONGPRESS_EN
          if (key_level[i] && hold_q[i] == HOLD_MAX) begin
            pend_d[i]  = 1'b1;
            plong_d[i] = 1'b1;
            state_d[i] = KS_LONG_SENT;
          end else if (!key_level[i]) begin
            pend_d[i]  = 1'b1;
            plong_d[i] = 1'b0;
            state_d[i] = KS_IDLE;
          end else if (hold_q[i] != HOLD_MAX) begin
            hold_d[i] = hold_q[i] + 1'b1;
          end
`else
          if (!key_level[i]) begin
            pend_d[i]  = 1'b1;
            plong_d[i] = 1'b0;
            state_d[i] = KS_IDLE;
          end
`endif
        end
        KS_LONG_SENT: begin
          if (!key_level[i]) state_d[i] = KS_IDLE;
        end
        default: state_d[i] = KS_IDLE;
      endcase
    end
  end

  always_comb begin
    pop     = evt.evt_ack && (cnt_q != '0);
    full    = (cnt_q == CW'(FIFO_DEPTH));
    push    = wr_en && (!full || pop);
    ovf_set = wr_en && full && !pop;
    cnt_d   = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= KS_IDLE;
`ifdef WALLET_KEY_LONGPRESS_EN
        hold_q[i]  <= '0;
`endif
      end
      for (int j = 0; j < FIFO_DEPTH; j++) mem_q[j] <= '0;
      pend_q   <= '0;
      plong_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
`ifdef WALLET_KEY_LONGPRESS_EN
      hold_q  <= hold_d;
`endif
      pend_q  <= pend_d;
      plong_q <= plong_d;
      cnt_q   <= cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= wr_evt;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign evt.evt_valid = (cnt_q != '0);
  assign evt.evt_key   = mem_q[rd_ptr_q].key;
  assign evt.evt_long  = mem_q[rd_ptr_q].is_long;
  assign evt_overflow  = ovf_q;
endmodule
